// File: rtl/ysyx_22050039_wb_arbiter.sv
// Round-robin arbiter that shares the single GPR write port between the EXU (req0) and the LSU (req1).
// Optional macro YSYX_22050039_WB_FWD_EN forwards the in-flight write onto the decoder read data.
module ysyx_22050039_wb_arbiter #(
  parameter int XLEN    = 64,
  parameter int REG_SEL = 5,
  parameter int NR_REG  = 32
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [REG_SEL-1:0] req0_rd,
  input  logic [XLEN-1:0]    req0_data,

  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [REG_SEL-1:0] req1_rd,
  input  logic [XLEN-1:0]    req1_data,

  output logic               wb_wen,
  output logic [REG_SEL-1:0] wb_rd,
  output logic [XLEN-1:0]    wb_data,

  input  logic [REG_SEL-1:0] rs1_addr,
  input  logic [REG_SEL-1:0] rs2_addr,
  input  logic [XLEN-1:0]    rf_rs1_data,
  input  logic [XLEN-1:0]    rf_rs2_data,
  output logic [XLEN-1:0]    rs1_data,
  output logic [XLEN-1:0]    rs2_data,

  output logic               last_grant
);

  if (NR_REG != (1 << REG_SEL)) begin : g_cfg_check
    $error("NR_REG must equal 2**REG_SEL");
  end

  // Handshake: a transfer happens in a cycle where valid && ready are both 1.
  // The requester holds valid/rd/data stable until then; ready is a pure function of
  // this cycle's valids and the round-robin pointer, and never depends on the register heap.
  logic grant0;
  logic grant1;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_wen     <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      last_grant <= 1'b1;
    end else if (grant0) begin
      wb_wen     <= (req0_rd != '0);
      wb_rd      <= req0_rd;
      wb_data    <= req0_data;
      last_grant <= 1'b0;
    end else if (grant1) begin
      wb_wen     <= (req1_rd != '0);
      wb_rd      <= req1_rd;
      wb_data    <= req1_data;
      last_grant <= 1'b1;
    end else begin
      // rd/data hold so the last write stays observable
      wb_wen     <= 1'b0;
    end
  end

`ifdef YSYX_22050039_WB_FWD_EN
  always_comb begin
    rs1_data = rf_rs1_data;
    rs2_data = rf_rs2_data;
    if (wb_wen && (wb_rd == rs1_addr) && (rs1_addr != '0)) begin
      rs1_data = wb_data;
    end
    if (wb_wen && (wb_rd == rs2_addr) && (rs2_addr != '0)) begin
      rs2_data = wb_data;
    end
  end
`else
  logic unused_rs_addr;
  assign unused_rs_addr = ^{rs1_addr, rs2_addr};
  assign rs1_data = rf_rs1_data;
  assign rs2_data = rf_rs2_data;
`endif

endmodule

// File: tb/tb_ysyx_22050039_wb_arbiter.sv
// Randomized bench for ysyx_22050039_wb_arbiter against a fair-sharing model of the write port.
// Expected forwarding follows the same YSYX_22050039_WB_FWD_EN macro as the design build.
module tb_ysyx_22050039_wb_arbiter;
  localparam int XLEN    = 64;
  localparam int REG_SEL = 5;
  localparam int W       = REG_SEL + XLEN;

  logic               clk = 1'b0;
  logic               rst;
  logic               req0_valid, req1_valid;
  logic               req0_ready, req1_ready;
  logic [REG_SEL-1:0] req0_rd, req1_rd;
  logic [XLEN-1:0]    req0_data, req1_data;
  logic               wb_wen;
  logic [REG_SEL-1:0] wb_rd;
  logic [XLEN-1:0]    wb_data;
  logic [REG_SEL-1:0] rs1_addr, rs2_addr;
  logic [XLEN-1:0]    rf_rs1_data, rf_rs2_data;
  logic [XLEN-1:0]    rs1_data, rs2_data;
  logic               last_grant;

  ysyx_22050039_wb_arbiter #(.XLEN(XLEN), .REG_SEL(REG_SEL), .NR_REG(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rd(req0_rd), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rd(req1_rd), .req1_data(req1_data),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .last_grant(last_grant)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard: writes that must appear on the port, in order, as {rd, data}
  logic [W-1:0] exp_q[$];

  // model of the port: who went last, and what the port currently shows
  int               m_last;
  bit               m_wen;
  logic [REG_SEL-1:0] m_rd;
  logic [XLEN-1:0]    m_data;
  bit               hs0, hs1;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_rs(input logic [REG_SEL-1:0] a, input logic [XLEN-1:0] rf);
`ifdef YSYX_22050039_WB_FWD_EN
    if (m_wen && m_rd == a && a != 0) return m_data;
`endif
    return rf;
  endfunction

  task automatic model_reset();
    m_last = 1;
    m_wen  = 1'b0;
    m_rd   = '0;
    m_data = '0;
    exp_q.delete();
  endtask

  // one clock cycle: check combinational outputs mid-cycle, then the registered port after the edge
  task automatic step();
    int g;
    logic [W-1:0] ent;
    @(negedge clk);
    check("rs1_data", rs1_data, exp_rs(rs1_addr, rf_rs1_data));
    check("rs2_data", rs2_data, exp_rs(rs2_addr, rf_rs2_data));
    if (rst)                          g = -1;
    else if (req0_valid && req1_valid) g = (m_last == 0) ? 1 : 0;
    else if (req0_valid)              g = 0;
    else if (req1_valid)              g = 1;
    else                              g = -1;
    check("req0_ready", req0_ready, (g == 0));
    check("req1_ready", req1_ready, (g == 1));
    hs0 = (g == 0);
    hs1 = (g == 1);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (g >= 0) begin
      m_last = g;
      m_rd   = (g == 1) ? req1_rd : req0_rd;
      m_data = (g == 1) ? req1_data : req0_data;
      m_wen  = (m_rd != 0);
      if (m_wen) exp_q.push_back({m_rd, m_data});
    end else begin
      m_wen = 1'b0;
    end
    #1;
    check("wb_wen", wb_wen, m_wen);
    check("last_grant", last_grant, m_last[0]);
    check("wb_rd_hold", wb_rd, m_rd);
    check("wb_data_hold", wb_data, m_data);
    if (m_wen && exp_q.size() > 0) begin
      ent = exp_q.pop_front();
      check("sb_rd", wb_rd, ent[W-1:XLEN]);
      check("sb_data", wb_data, ent[XLEN-1:0]);
    end
  endtask

  // driver tasks
  task automatic drive0(input logic v, input logic [REG_SEL-1:0] rd, input logic [XLEN-1:0] d);
    req0_valid = v; req0_rd = rd; req0_data = d;
  endtask

  task automatic drive1(input logic v, input logic [REG_SEL-1:0] rd, input logic [XLEN-1:0] d);
    req1_valid = v; req1_rd = rd; req1_data = d;
  endtask

  task automatic rand_reads();
    rs1_addr    = REG_SEL'($urandom_range(0, 7));
    rs2_addr    = REG_SEL'($urandom_range(0, 7));
    rf_rs1_data = {$urandom, $urandom};
    rf_rs2_data = {$urandom, $urandom};
  endtask

  initial begin
    rst = 1'b1;
    drive0(1'b0, '0, '0);
    drive1(1'b0, '0, '0);
    rs1_addr = '0; rs2_addr = '0; rf_rs1_data = '0; rf_rs2_data = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_wb_wen", wb_wen, 1'b0);
    check("rst_wb_rd", wb_rd, '0);
    check("rst_wb_data", wb_data, '0);
    check("rst_last_grant", last_grant, 1'b1);
    check("rst_req0_ready", req0_ready, 1'b0);
    check("rst_req1_ready", req1_ready, 1'b0);
    rst = 1'b0;

    // single write from req0, then idle
    drive0(1'b1, 5'd5, 64'h1234);
    step();
    check("t1_wb_rd", wb_rd, 5);
    check("t1_wb_data", wb_data, 64'h1234);
    drive0(1'b0, '0, '0);
    step();
    check("t1_idle_wen", wb_wen, 1'b0);

    // first contention after reset: req0 wins, then req1
    rst = 1'b1; step(); rst = 1'b0;
    drive0(1'b1, 5'd3, 64'hA);
    drive1(1'b1, 5'd4, 64'hB);
    step();
    check("t2_first_rd", wb_rd, 3);
    drive0(1'b0, '0, '0);
    step();
    check("t2_second_rd", wb_rd, 4);
    check("t2_last_grant", last_grant, 1'b1);
    drive1(1'b0, '0, '0);
    step();

    // sustained contention with fresh data per handshake
    drive0(1'b1, 5'd10, {$urandom, $urandom});
    drive1(1'b1, 5'd11, {$urandom, $urandom});
    for (int i = 0; i < 6; i++) begin
      step();
      check("t3_alt_rd", wb_rd, (i % 2 == 0) ? 10 : 11);
      if (hs0) drive0(1'b1, 5'd10, {$urandom, $urandom});
      if (hs1) drive1(1'b1, 5'd11, {$urandom, $urandom});
    end
    drive0(1'b0, '0, '0);
    drive1(1'b0, '0, '0);
    step();

    // write to x0 is accepted but never strobed
    drive1(1'b1, 5'd0, 64'hFF);
    step();
    check("t4_x0_wen", wb_wen, 1'b0);
    check("t4_x0_last", last_grant, 1'b1);
    drive1(1'b0, '0, '0);
    step();

    // reset right after a handshake drops the pending strobe
    drive0(1'b1, 5'd7, 64'h77);
    step();
    check("t5_pending_wen", wb_wen, 1'b1);
    drive0(1'b0, '0, '0);
    drive1(1'b1, 5'd8, 64'h88);
    rst = 1'b1;
    step();
    check("t5_after_rst_wen", wb_wen, 1'b0);
    rst = 1'b0;
    drive0(1'b1, 5'd6, 64'h66);
    step();
    check("t5_restart_rd", wb_rd, 6);
    drive0(1'b0, '0, '0);
    step();
    drive1(1'b0, '0, '0);

    // forwarding of the in-flight write
    drive0(1'b1, 5'd9, 64'h55);
    step();
    drive0(1'b0, '0, '0);
    rs1_addr = 5'd9; rf_rs1_data = 64'h11;
    #1;
`ifdef YSYX_22050039_WB_FWD_EN
    check("t6_fwd_rs1", rs1_data, 64'h55);
`else
    check("t6_fwd_rs1", rs1_data, 64'h11);
`endif
    rs1_addr = 5'd0;
    #1;
    check("t6_x0_rs1", rs1_data, 64'h11);
    step();

    // randomized traffic with small rd range for collisions and x0
    for (int i = 0; i < 400; i++) begin
      if (!req0_valid || hs0)
        drive0(1'($urandom_range(0, 3) != 0), REG_SEL'($urandom_range(0, 7)), {$urandom, $urandom});
      if (!req1_valid || hs1)
        drive1(1'($urandom_range(0, 3) != 0), REG_SEL'($urandom_range(0, 7)), {$urandom, $urandom});
      rand_reads();
      rst = ($urandom_range(0, 49) == 0);
      if (rst) begin
        drive0(1'b0, '0, '0);
        drive1(1'b0, '0, '0);
      end
      step();
      rst = 1'b0;
    end

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
